sci_fifo_drain: RTL and testbench
=================================

Name: sci_fifo_drain

Overview:
- Downstream consumer of the accelerator's result/command FIFO. Pops one entry at a time using the FIFO's RD/EMPTY interface and unpacks the {data, mode, res} word.
- Converts the one-hot mode field to a binary index, flags illegal modes, and presents the entry on a valid/ready interface to the next stage (writeback/output formatter).
- Keeps at most one read in flight, because the FIFO's dataOut is registered and its EMPTY flag updates one cycle after a pop.

Parameters:
- DATA_WIDTH, 32, operand/result data field width (from package).
- NUM_MODES, 8, one-hot mode field width (from package).
- RES_WIDTH, 8, residual/tag field width (from package).
- MODE_IDX_W, $clog2(NUM_MODES), width of the binary mode index (derived; not overridden).

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous reset, active-high.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_data  in  DATA_WIDTH+NUM_MODES+RES_WIDTH  FIFO dataOut.
- fifo_rd  out  1  FIFO RD strobe.
- fifo_en  out  1  FIFO EN; 1 whenever not in reset.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  data field.
- out_mode  out  MODE_IDX_W  binary index of the mode bit.
- out_res  out  RES_WIDTH  res field.
- out_mode_err  out  1  mode field not exactly one-hot; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Word layout: data = [W-1 -: DATA_WIDTH]; mode = next NUM_MODES bits; res = [RES_WIDTH-1:0].
- FSM states: IDLE, POP, WAIT, CAPT, HOLD.
  - IDLE: if !fifo_empty, go to POP.
  - POP: fifo_rd=1 for exactly this cycle; go to WAIT.
  - WAIT: fifo_rd=0; go to CAPT. The FIFO's dataOut and Count settle during this cycle.
  - CAPT: register fifo_data fields into the output registers; go to HOLD.
  - HOLD: out_valid=1.
    - out_ready=1: the entry transfers this cycle. Go to POP if !fifo_empty, else IDLE.
    - out_ready=0: stay in HOLD; outputs stay stable.
- fifo_rd is asserted only in POP. It is never asserted when fifo_empty was 1 in the deciding cycle.
- Latency:
  - Non-empty FIFO seen in IDLE at cycle t: out_valid first high at t+4.
  - Back-to-back steady-state throughput: 1 entry per 4 cycles with out_ready held at 1.
- Mode decode:
  - One-hot: out_mode = index of the set bit, out_mode_err = 0.
  - Zero bits or more than one bit set: out_mode_err = 1, out_mode = index of the lowest set bit, or 0 if none set.
  - The entry is still delivered.
- out_* data registers change only in CAPT; valid/ready holding rules apply.
- Reset (sync, any state):
  - Next cycle: state=IDLE, fifo_rd=0, out_valid=0, out_mode_err=0, out_data/out_mode/out_res=0, busy=0.
  - fifo_en=0 while Rst=1.
  - An entry popped but not yet delivered is discarded.
- fifo_empty rising while in HOLD has no effect until the handshake completes.

Optional Feature:
- Macro SCI_FIFO_DRAIN_PERF_EN.
- Defined: adds output ports drain_cnt (32b) and stall_cnt (32b).
  - drain_cnt increments on each out_valid&out_ready.
  - stall_cnt increments on each out_valid&!out_ready cycle.
  - Both saturate at all-ones and clear on Rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sci_acc_pkg holds:
  - DATA_WIDTH, NUM_MODES, RES_WIDTH, FIFO_DEPTH, FIFO_CNT_WIDTH;
  - a typedef fifo_word_t, packed struct {data, mode, res};
  - the drain FSM state enum.
- One sub-module: sci_onehot_dec. Combinational, NUM_MODES input; outputs idx and err. Reusable by the mode-dispatch logic.

Test Plan:
- Single entry: push {data=32'hDEADBEEF, mode=8'b0000_0100, res=8'h5A}, out_ready=1.
  - fifo_rd pulses 1 cycle.
  - out_valid rises 4 cycles after fifo_empty falls.
  - Outputs: out_data=DEADBEEF, out_mode=2, out_res=5A, out_mode_err=0.
- Backpressure: 3 entries queued, out_ready=0 for 10 cycles, then 1.
  - out_* stable through the stall; no extra fifo_rd during HOLD.
  - All 3 entries delivered in order.
  - With PERF_EN: stall_cnt=10, drain_cnt=3.
- Illegal modes:
  - mode=8'b0 gives out_mode_err=1, out_mode=0.
  - mode=8'b0001_0010 gives out_mode_err=1, out_mode=1.
  - Both entries are delivered.
- Empty FIFO: fifo_empty=1 for 50 cycles gives fifo_rd=0, out_valid=0, busy=0 throughout.
- Reset mid-operation: assert Rst in WAIT, then in HOLD.
  - Next cycle: out_valid=0, fifo_rd=0, state IDLE.
  - After release, the next queued entry is delivered normally.
- Full drain: FIFO filled to FIFO_DEPTH, out_ready=1.
  - Exactly FIFO_DEPTH transfers, in write order.
  - fifo_rd count equals FIFO_DEPTH; ends in IDLE.

Source files
------------

// File: rtl/sci_acc_pkg.sv
// Shared types and sizes for the accelerator result/command FIFO and its drain logic.
package sci_acc_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int NUM_MODES      = 8;
    localparam int RES_WIDTH      = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int MODE_IDX_W     = $clog2(NUM_MODES);
    localparam int WORD_WIDTH     = DATA_WIDTH + NUM_MODES + RES_WIDTH;

    // Field order puts data in the MSBs and res in the LSBs of the FIFO word.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [NUM_MODES-1:0]  mode;
        logic [RES_WIDTH-1:0]  res;
    } fifo_word_t;

    typedef enum logic [2:0] {
        DRAIN_IDLE,
        DRAIN_POP,
        DRAIN_WAIT,
        DRAIN_CAPT,
        DRAIN_HOLD
    } drain_state_t;

endpackage

// File: rtl/sci_onehot_dec.sv
// One-hot to binary decoder: idx is the lowest set bit (0 if none), err flags
// a field that is not exactly one-hot.
module sci_onehot_dec #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             err
);

    logic [N-1:0] below;

    assign below = onehot - N'(1);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
    end

    // Clearing the lowest set bit leaves nonzero iff more than one bit was set.
    assign err = (onehot == '0) || ((onehot & below) != '0);

endmodule

// File: rtl/sci_fifo_drain.sv
// Drains the accelerator result FIFO one entry at a time onto a valid/ready port.
// Define SCI_FIFO_DRAIN_PERF_EN to add saturating drain/stall counters.
//
// state | meaning
// IDLE  | no entry held, waiting for FIFO non-empty
// POP   | fifo_rd strobe for one cycle
// WAIT  | FIFO dataOut and EMPTY settle after the pop
// CAPT  | register the unpacked word into the output registers
// HOLD  | out_valid high until downstream accepts
module sci_fifo_drain
    import sci_acc_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  fifo_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [MODE_IDX_W-1:0] out_mode,
    output logic [RES_WIDTH-1:0]  out_res,
    output logic                  out_mode_err,
    output logic                  busy
`ifdef SCI_FIFO_DRAIN_PERF_EN
    ,
    output logic [31:0]           drain_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    drain_state_t          state;
    fifo_word_t            word;
    logic [MODE_IDX_W-1:0] dec_idx;
    logic                  dec_err;

    assign word    = fifo_word_t'(fifo_data);
    assign fifo_en = ~Rst;
    assign busy    = (state != DRAIN_IDLE);

    sci_onehot_dec #(
        .N     (NUM_MODES),
        .IDX_W (MODE_IDX_W)
    ) u_mode_dec (
        .onehot (word.mode),
        .idx    (dec_idx),
        .err    (dec_err)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= DRAIN_IDLE;
            fifo_rd      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_mode     <= '0;
            out_res      <= '0;
            out_mode_err <= 1'b0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= DRAIN_POP;
                        fifo_rd <= 1'b1;
                    end
                end
                DRAIN_POP: begin
                    state   <= DRAIN_WAIT;
                    fifo_rd <= 1'b0;
                end
                DRAIN_WAIT: begin
                    state <= DRAIN_CAPT;
                end
                DRAIN_CAPT: begin
                    out_data     <= word.data;
                    out_mode     <= dec_idx;
                    out_res      <= word.res;
                    out_mode_err <= dec_err;
                    out_valid    <= 1'b1;
                    state        <= DRAIN_HOLD;
                end
                DRAIN_HOLD: begin
                    // EMPTY is only consulted once the held entry has transferred.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!fifo_empty) begin
                            state   <= DRAIN_POP;
                            fifo_rd <= 1'b1;
                        end else begin
                            state <= DRAIN_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= DRAIN_IDLE;
                    fifo_rd   <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCI_FIFO_DRAIN_PERF_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else if (out_valid) begin
            if (out_ready) begin
                if (drain_cnt != '1) drain_cnt <= drain_cnt + 32'd1;
            end else begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sci_fifo_drain.sv
// Self-checking bench for sci_fifo_drain: behavioural FIFO model plus an
// in-order scoreboard of expected output entries.
module tb_sci_fifo_drain;
    import sci_acc_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Rst = 1'b1;
    logic                  fifo_empty = 1'b1;
    logic [WORD_WIDTH-1:0] fifo_data = '0;
    logic                  fifo_rd;
    logic                  fifo_en;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DATA_WIDTH-1:0] out_data;
    logic [MODE_IDX_W-1:0] out_mode;
    logic [RES_WIDTH-1:0]  out_res;
    logic                  out_mode_err;
    logic                  busy;
`ifdef SCI_FIFO_DRAIN_PERF_EN
    logic [31:0]           drain_cnt;
    logic [31:0]           stall_cnt;
`endif

    sci_fifo_drain dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd      (fifo_rd),
        .fifo_en      (fifo_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .out_res      (out_res),
        .out_mode_err (out_mode_err),
        .busy         (busy)
`ifdef SCI_FIFO_DRAIN_PERF_EN
        ,
        .drain_cnt    (drain_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [MODE_IDX_W-1:0] mode;
        logic [RES_WIDTH-1:0]  res;
        logic                  err;
    } exp_t;

    fifo_word_t fifo_q[$];
    exp_t       pend_q[$];
    exp_t       infl_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int dl_cnt = 0;
    int t_fall = 0;
    logic lat_arm = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_empty = 1'b1;
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    logic [63:0] held = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t ref_exp(input logic [31:0] d, input logic [7:0] m, input logic [7:0] r);
        exp_t e;
        int   ones;
        logic found;
        e.data = d;
        e.res  = r;
        e.mode = '0;
        ones   = 0;
        found  = 1'b0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (m[i]) begin
                ones++;
                if (!found) begin
                    e.mode = MODE_IDX_W'(i);
                    found  = 1'b1;
                end
            end
        end
        e.err = (ones != 1);
        return e;
    endfunction

    // FIFO model: registered dataOut on pop, EMPTY updated one edge later.
    always @(posedge Clk) begin
        cyc++;
        if (fifo_rd && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
            infl_q.push_back(pend_q.pop_front());
        end
        if (Rst) infl_q.delete();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst) begin
            if (fifo_rd) begin
                rd_cnt++;
                check_val("rd_pulse_width", 64'(prev_rd), 64'd0);
                check_val("rd_after_nonempty", 64'(prev_empty), 64'd0);
            end
            if (lat_arm && prev_empty && !fifo_empty) t_fall = cyc;
            if (lat_arm && out_valid && !prev_valid) begin
                check_val("latency", 64'(cyc - t_fall), 64'd4);
                lat_arm = 1'b0;
            end
            if (out_valid && out_ready) begin
                dl_cnt++;
                check_val("sb_has_entry", 64'(infl_q.size() != 0), 64'd1);
                if (infl_q.size() != 0) begin
                    e = infl_q.pop_front();
                    check_val("out_data", 64'(out_data), 64'(e.data));
                    check_val("out_mode", 64'(out_mode), 64'(e.mode));
                    check_val("out_res", 64'(out_res), 64'(e.res));
                    check_val("out_mode_err", 64'(out_mode_err), 64'(e.err));
                end
            end
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    check_val("hold_stable", 64'({out_data, out_mode, out_res, out_mode_err}), held);
                    check_val("hold_no_rd", 64'(fifo_rd), 64'd0);
                end
                held = 64'({out_data, out_mode, out_res, out_mode_err});
            end
            prev_stall = out_valid && !out_ready;
        end else begin
            prev_stall = 1'b0;
        end
        prev_rd    = fifo_rd;
        prev_empty = fifo_empty;
        prev_valid = out_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [7:0] m, input logic [7:0] r);
        fifo_word_t w;
        w.data = d;
        w.mode = m;
        w.res  = r;
        fifo_q.push_back(w);
        pend_q.push_back(ref_exp(d, m, r));
    endtask

    task automatic wait_drained(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step(1);
            done = (fifo_q.size() == 0) && (infl_q.size() == 0) && !busy && fifo_empty;
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_signal(input string tag, input int budget, input logic want_rd);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            seen = want_rd ? fifo_rd : out_valid;
        end
        check_val(tag, 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
        step(1);
    endtask

    initial begin
        int rd0;
        int dl0;

        // Reset state
        step(2);
        check_val("rst_fifo_en", 64'(fifo_en), 64'd0);
        check_val("rst_ctrl", 64'({fifo_rd, out_valid, busy, out_mode_err}), 64'd0);
        check_val("rst_data", 64'({out_data, out_mode, out_res}), 64'd0);
        Rst = 1'b0;
        step(1);
        check_val("run_fifo_en", 64'(fifo_en), 64'd1);

        // Single entry with latency
        rd0 = rd_cnt; dl0 = dl_cnt;
        lat_arm = 1'b1;
        push_word(32'hDEADBEEF, 8'b0000_0100, 8'h5A);
        wait_drained("single_done", 40);
        check_val("single_rd_cnt", 64'(rd_cnt - rd0), 64'd1);
        check_val("single_dl_cnt", 64'(dl_cnt - dl0), 64'd1);
        check_val("latency_seen", 64'(lat_arm), 64'd0);

        // Backpressure: 3 queued, 10-cycle stall
        do_reset();
        rd0 = rd_cnt; dl0 = dl_cnt;
        out_ready = 1'b0;
        push_word(32'h1111_0001, 8'b0000_0001, 8'h01);
        push_word(32'h2222_0002, 8'b1000_0000, 8'h02);
        push_word(32'h3333_0003, 8'b0010_0000, 8'h03);
        wait_signal("bp_valid", 20, 1'b0);
        step(10);
        out_ready = 1'b1;
        wait_drained("bp_done", 60);
        check_val("bp_rd_cnt", 64'(rd_cnt - rd0), 64'd3);
        check_val("bp_dl_cnt", 64'(dl_cnt - dl0), 64'd3);
`ifdef SCI_FIFO_DRAIN_PERF_EN
        check_val("perf_stall_cnt", 64'(stall_cnt), 64'd10);
        check_val("perf_drain_cnt", 64'(drain_cnt), 64'd3);
`endif

        // Illegal modes
        dl0 = dl_cnt;
        push_word(32'hA5A5_0000, 8'b0000_0000, 8'hC0);
        push_word(32'h5A5A_FFFF, 8'b0001_0010, 8'hC1);
        wait_drained("illegal_done", 40);
        check_val("illegal_dl_cnt", 64'(dl_cnt - dl0), 64'd2);

        // Empty FIFO stays quiet
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_val("empty_quiet", 64'({fifo_rd, out_valid, busy}), 64'd0);
        end

        // Reset while in WAIT
        dl0 = dl_cnt;
        push_word(32'hBAD0_0001, 8'b0000_0010, 8'h11);
        push_word(32'h600D_0002, 8'b0100_0000, 8'h22);
        wait_signal("wait_rd_seen", 20, 1'b1);
        step(1);
        Rst = 1'b1;
        step(1);
        check_val("rst_wait_ctrl", 64'({out_valid, fifo_rd, busy}), 64'd0);
        Rst = 1'b0;
        wait_drained("rst_wait_done", 40);
        check_val("rst_wait_dl_cnt", 64'(dl_cnt - dl0), 64'd1);

        // Reset while in HOLD
        dl0 = dl_cnt;
        out_ready = 1'b0;
        push_word(32'hBAD0_0003, 8'b0000_1000, 8'h33);
        wait_signal("hold_valid", 20, 1'b0);
        Rst = 1'b1;
        step(1);
        check_val("rst_hold_ctrl", 64'({out_valid, fifo_rd, busy}), 64'd0);
        Rst = 1'b0;
        out_ready = 1'b1;
        push_word(32'h600D_0004, 8'b0000_0001, 8'h44);
        wait_drained("rst_hold_done", 40);
        check_val("rst_hold_dl_cnt", 64'(dl_cnt - dl0), 64'd1);

        // Full drain of FIFO_DEPTH entries
        rd0 = rd_cnt; dl0 = dl_cnt;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push_word(32'hF000_0000 + 32'(i), 8'(1 << (i % NUM_MODES)), 8'(i * 3));
        end
        wait_drained("full_done", FIFO_DEPTH * 4 + 40);
        check_val("full_rd_cnt", 64'(rd_cnt - rd0), 64'(FIFO_DEPTH));
        check_val("full_dl_cnt", 64'(dl_cnt - dl0), 64'(FIFO_DEPTH));
        check_val("full_idle", 64'({busy, out_valid}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
